frame_symbolizer: RTL and testbench
===================================

# frame_symbolizer

Upstream stage of the 8b/10b encoder. Takes a byte stream with a valid/ready handshake and a last flag, and wraps each frame in control characters plus an XOR checksum. Emits one 9-bit symbol {K, byte} per symbol period, paced for a downstream 10:1 serializer on the same clock. Between frames it emits K28.5 comma/idle symbols, so the link always carries traffic.

## Interface
Parameters:
- SYM_DIV, 10: clocks per symbol period; legal range 2..255.
- MIN_IDLE, 2: minimum K28.5 symbols between EOF and the next SOF (also applies after reset); 0 is legal.
- MAX_LEN, 256: maximum payload bytes per frame; 1..65535.

Ports:
- clk  in  1  single clock for the whole block.
- rst  in  1  synchronous, active-high reset.
- s_data  in  8  payload byte.
- s_last  in  1  marks the final byte of a frame; qualified by s_valid.
- s_valid  in  1  s_data and s_last are valid.
- s_ready  out  1  block accepts a byte this cycle.
- sym_out  out  9  symbol to the encoder datain; bit 8 = K flag.
- sym_stb  out  1  one-cycle pulse: sym_out holds a new symbol.
- frame_cnt  out  16  number of completed frames; wraps at 2^16.
- trunc_err  out  1  sticky flag: a frame exceeded MAX_LEN; cleared only by rst.

## Operation
- Symbol constants: IDLE K28.5 = 9'h1BC, SOF K28.1 = 9'h13C, EOF K29.7 = 9'h1FD, FILL = IDLE. Data symbols are {1'b0, byte}.
- Divider div_cnt counts 0..SYM_DIV-1 and wraps. tick = (div_cnt == SYM_DIV-1). The FSM advances only on tick cycles.
- States: IDLE, SOF, DATA, CHK, EOF, DISCARD.
- IDLE: emits IDLE and increments idle_cnt, saturating at MIN_IDLE. If idle_cnt ≥ MIN_IDLE and s_valid is high at tick, go to SOF. The byte is not consumed.
- SOF: emits SOF, clears chk and len, goes to DATA.
- DATA: s_ready = tick & s_valid-independent (s_ready is high on every DATA tick).
  - Byte accepted: emit byte, update chk ^= byte and len += 1.
  - If s_last, go to CHK.
  - Else if len+1 == MAX_LEN, set trunc_err and go to DISCARD.
  - Not accepted (s_valid low): emit FILL and stay in DATA. FILL does not count toward len or chk.
- DISCARD: emits FILL each tick; s_ready = 1 every cycle (not only on tick). Drops bytes until one arrives with s_last, then goes to CHK at the next tick.
- CHK: emits {0, chk}, goes to EOF.
- EOF: emits EOF, increments frame_cnt, clears idle_cnt, goes to IDLE.
- Only DATA and DISCARD ever assert s_ready.
- Truncated-frame checksum: the XOR of the MAX_LEN bytes actually sent.
- A byte with s_last accepted while len+1 == MAX_LEN: s_last wins. Go to CHK; trunc_err is not set.

## Timing
- Reset values: sym_out = 9'h1BC, sym_stb = 0, s_ready = 0, frame_cnt = 0, trunc_err = 0. Internal state: state = IDLE, div_cnt = 0, idle_cnt = 0, len = 0, chk = 0.
- First tick is SYM_DIV-1 cycles after rst deasserts.
- Symbol decided on the tick cycle is registered at that edge. sym_out changes and sym_stb pulses in the cycle after tick. sym_out is then stable for SYM_DIV cycles.
- s_ready is combinational from state and tick. Transfer occurs on s_valid & s_ready at the rising edge.
- Minimum frame on the wire is SOF, byte, CHK, EOF: 4 symbol periods.
- Back-to-back frames are separated by exactly MIN_IDLE IDLE symbols when s_valid is held high.
- rst mid-frame: aborts immediately to the reset values. No EOF is emitted. The partially sent frame is the receiver's problem.

## Structure
- Shared package frame_sym_pkg holds:
  - 9-bit symbol constants K_IDLE, K_SOF, K_EOF.
  - the state enum.
  - the same constants for the downstream deframer.
- Sub-module sym_tick_gen: the SYM_DIV divider producing tick. It is reused by the serializer so both stay phase-aligned.
- Target RTL size: ~200 lines.

## Test plan
- Reset, s_valid = 0 for 50 cycles, SYM_DIV = 10 → sym_out = 9'h1BC throughout; sym_stb on cycles 10, 20, 30, 40, 50 after reset; s_ready never high.
- Frame {0x12, 0x34, 0x56 last} presented continuously after reset, MIN_IDLE = 2 → symbol sequence 1BC, 1BC, 13C, 012, 034, 056, 070, 1FD, 1BC; frame_cnt = 1.
- Same frame with s_valid dropped for 2 symbol periods after 0x34 → 012, 034, 1BC, 1BC, 056, 070, 1FD; chk unaffected by the fills.
- MAX_LEN = 4, 7-byte frame 0x01..0x07 → 13C, 001..004, 1BC (DISCARD) symbols while 0x05..0x07 are drained, then 004 (chk = 0x01^0x02^0x03^0x04), 1FD; trunc_err = 1.
- Two back-to-back 1-byte frames 0xAA, 0x55 → 13C 0AA 0AA 1FD 1BC 1BC 13C 055 055 1FD; frame_cnt = 2.
- rst asserted during the DATA state of a frame → next cycle sym_out = 1BC, s_ready = 0, frame_cnt unchanged from reset (0); following frame starts after MIN_IDLE idles.

Source files
------------

// File: rtl/frame_sym_pkg.sv
// frame_sym_pkg
//   Shared definitions for the frame symbolizer and the downstream deframer.
//   Holds the 9-bit {K, byte} symbol constants, the symbolizer state enum
//   and a helper that builds a data symbol from a payload byte.
package frame_sym_pkg;

  localparam int SYM_W = 9;

  // Control symbols as {K flag, byte}.
  localparam logic [SYM_W-1:0] K_IDLE = 9'h1BC;  // K28.5 comma / idle
  localparam logic [SYM_W-1:0] K_SOF  = 9'h13C;  // K28.1 start of frame
  localparam logic [SYM_W-1:0] K_EOF  = 9'h1FD;  // K29.7 end of frame
  localparam logic [SYM_W-1:0] K_FILL = K_IDLE;  // in-frame filler when no byte is ready

  // Names used on the receive side; kept identical to the transmit values.
  localparam logic [SYM_W-1:0] DF_K_IDLE = K_IDLE;
  localparam logic [SYM_W-1:0] DF_K_SOF  = K_SOF;
  localparam logic [SYM_W-1:0] DF_K_EOF  = K_EOF;
  localparam logic [SYM_W-1:0] DF_K_FILL = K_FILL;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOF,
    ST_DATA,
    ST_CHK,
    ST_EOF,
    ST_DISCARD
  } frame_state_e;

  function automatic logic [SYM_W-1:0] data_sym(input logic [7:0] b);
    return {1'b0, b};
  endfunction

endpackage

// File: rtl/sym_tick_gen.sv
// sym_tick_gen
//   Symbol-period divider. Counts 0..SYM_DIV-1 and wraps; tick_o is high in
//   the last cycle of every period. Shared with the serializer so both sides
//   see the same symbol phase.
// Ports:
//   clk    - clock
//   rst    - synchronous active-high reset (counter restarts at 0)
//   tick_o - one cycle high every SYM_DIV cycles
module sym_tick_gen #(
  parameter int SYM_DIV = 10
) (
  input  logic clk,
  input  logic rst,
  output logic tick_o
);

  localparam int CW = $clog2(SYM_DIV);

  logic [CW-1:0] div_cnt_q, div_cnt_d;

  assign tick_o = (div_cnt_q == CW'(SYM_DIV - 1));

  always_comb begin
    div_cnt_d = div_cnt_q + 1'b1;
    if (tick_o) div_cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) div_cnt_q <= '0;
    else     div_cnt_q <= div_cnt_d;
  end

endmodule

// File: rtl/frame_symbolizer.sv
// frame_symbolizer
//   Wraps a valid/ready/last byte stream into frames of
//   SOF, payload bytes, XOR checksum, EOF, emitting one 9-bit {K, byte}
//   symbol per SYM_DIV-cycle symbol period. K28.5 idles fill the gaps
//   between frames (at least MIN_IDLE of them). Frames longer than MAX_LEN
//   are cut at MAX_LEN bytes, the remainder is drained and trunc_err latches.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   s_data/s_last     - payload byte and end-of-frame marker
//   s_valid/s_ready   - input handshake (transfer on both high at the edge)
//   sym_out/sym_stb   - registered symbol and its one-cycle update strobe
//   frame_cnt         - completed frames, wraps at 2^16
//   trunc_err         - sticky over-length flag
module frame_symbolizer
  import frame_sym_pkg::*;
#(
  parameter int SYM_DIV  = 10,
  parameter int MIN_IDLE = 2,
  parameter int MAX_LEN  = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_data,
  input  logic        s_last,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [8:0]  sym_out,
  output logic        sym_stb,
  output logic [15:0] frame_cnt,
  output logic        trunc_err
);

  logic         tick;
  frame_state_e state_q, state_d;
  logic [8:0]   sym_q, sym_d;
  logic         sym_stb_q;
  logic [7:0]   chk_q, chk_d;
  logic [15:0]  len_q, len_d;
  logic [15:0]  idle_cnt_q, idle_cnt_d;
  logic [15:0]  frame_cnt_q, frame_cnt_d;
  logic         trunc_q, trunc_d;
  logic         last_seen_q, last_seen_d;
  logic         accept;
  logic         len_at_max;
  logic [15:0]  idle_inc;

  sym_tick_gen #(
    .SYM_DIV(SYM_DIV)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .tick_o(tick)
  );

  // DATA takes at most one byte per symbol period, on the tick.
  // DISCARD drains at full clock rate, but stops once the frame's last byte
  // has gone so the next frame's first byte is held for its own SOF.
  always_comb begin
    s_ready = 1'b0;
    if (state_q == ST_DATA)         s_ready = tick;
    else if (state_q == ST_DISCARD) s_ready = ~last_seen_q;
  end

  assign accept     = s_valid & s_ready;
  assign len_at_max = (({1'b0, len_q} + 17'd1) == 17'(MAX_LEN));
  // Idle count after this IDLE symbol, saturating at MIN_IDLE; the SOF
  // decision uses it so exactly MIN_IDLE idles separate frames.
  assign idle_inc   = (idle_cnt_q < 16'(MIN_IDLE)) ? idle_cnt_q + 16'd1 : idle_cnt_q;

  always_comb begin
    state_d     = state_q;
    sym_d       = sym_q;
    chk_d       = chk_q;
    len_d       = len_q;
    idle_cnt_d  = idle_cnt_q;
    frame_cnt_d = frame_cnt_q;
    trunc_d     = trunc_q;
    last_seen_d = last_seen_q;

    // Remember a last byte dropped between ticks.
    if ((state_q == ST_DISCARD) && accept && s_last) last_seen_d = 1'b1;

    if (tick) begin
      unique case (state_q)
        ST_IDLE: begin
          sym_d      = K_IDLE;
          idle_cnt_d = idle_inc;
          if ((idle_inc >= 16'(MIN_IDLE)) && s_valid) state_d = ST_SOF;
        end
        ST_SOF: begin
          sym_d       = K_SOF;
          chk_d       = 8'h00;
          len_d       = 16'd0;
          last_seen_d = 1'b0;
          state_d     = ST_DATA;
        end
        ST_DATA: begin
          if (accept) begin
            sym_d = data_sym(s_data);
            chk_d = chk_q ^ s_data;
            len_d = len_q + 16'd1;
            // A last byte landing exactly on MAX_LEN closes the frame cleanly.
            if (s_last) begin
              state_d = ST_CHK;
            end else if (len_at_max) begin
              trunc_d = 1'b1;
              state_d = ST_DISCARD;
            end
          end else begin
            sym_d = K_FILL;
          end
        end
        ST_DISCARD: begin
          sym_d = K_FILL;
          if (last_seen_q || (accept && s_last)) begin
            last_seen_d = 1'b0;
            state_d     = ST_CHK;
          end
        end
        ST_CHK: begin
          sym_d   = data_sym(chk_q);
          state_d = ST_EOF;
        end
        ST_EOF: begin
          sym_d       = K_EOF;
          frame_cnt_d = frame_cnt_q + 16'd1;
          idle_cnt_d  = 16'd0;
          state_d     = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sym_q       <= K_IDLE;
      sym_stb_q   <= 1'b0;
      chk_q       <= 8'h00;
      len_q       <= 16'd0;
      idle_cnt_q  <= 16'd0;
      frame_cnt_q <= 16'd0;
      trunc_q     <= 1'b0;
      last_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sym_q       <= sym_d;
      sym_stb_q   <= tick;
      chk_q       <= chk_d;
      len_q       <= len_d;
      idle_cnt_q  <= idle_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      trunc_q     <= trunc_d;
      last_seen_q <= last_seen_d;
    end
  end

  assign sym_out   = sym_q;
  assign sym_stb   = sym_stb_q;
  assign frame_cnt = frame_cnt_q;
  assign trunc_err = trunc_q;

endmodule

// File: tb/tb_frame_symbolizer.sv
// Bench for frame_symbolizer: directed frames with exact symbol sequences,
// then random frames checked against a frame-level reference
// (SOF, first MAX_LEN bytes, XOR, EOF) with idle symbols stripped.
module tb_frame_symbolizer;

  localparam int SYM_DIV  = 10;
  localparam int MIN_IDLE = 2;
  localparam int MAX_LEN  = 4;
  localparam int N_RAND   = 30;

  localparam logic [8:0] S_IDLE = 9'h1BC;
  localparam logic [8:0] S_SOF  = 9'h13C;
  localparam logic [8:0] S_EOF  = 9'h1FD;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s_data;
  logic        s_last;
  logic        s_valid;
  logic        s_ready;
  logic [8:0]  sym_out;
  logic        sym_stb;
  logic [15:0] frame_cnt;
  logic        trunc_err;

  frame_symbolizer #(
    .SYM_DIV (SYM_DIV),
    .MIN_IDLE(MIN_IDLE),
    .MAX_LEN (MAX_LEN)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .s_data   (s_data),
    .s_last   (s_last),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .sym_out  (sym_out),
    .sym_stb  (sym_stb),
    .frame_cnt(frame_cnt),
    .trunc_err(trunc_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       last;
    int         gap;   // cycles with s_valid low before this byte is offered
  } beat_t;

  beat_t      stream[$];
  logic [8:0] mon_q[$];
  logic [8:0] exp_q[$];
  int vecs = 0;
  int errs = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vecs++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock; outputs sampled 1 time unit after the edge.
  task automatic cycle();
    @(posedge clk);
    #1;
    if (sym_stb === 1'b1) mon_q.push_back(sym_out);
  endtask

  task automatic push_beat(input logic [7:0] d, input logic l, input int g);
    beat_t b;
    b.data = d;
    b.last = l;
    b.gap  = g;
    stream.push_back(b);
  endtask

  // Feeds the stream; a byte stays on the bus until it is taken.
  task automatic drive(input int budget);
    int  cyc;
    bit  took;
    cyc = 0;
    while (stream.size() > 0 && cyc < budget) begin
      if (!s_valid) begin
        if (stream[0].gap > 0) begin
          stream[0].gap = stream[0].gap - 1;
        end else begin
          s_valid = 1'b1;
          s_data  = stream[0].data;
          s_last  = stream[0].last;
        end
      end
      took = s_valid && s_ready;
      cycle();
      cyc++;
      if (took) begin
        void'(stream.pop_front());
        s_valid = 1'b0;
        s_data  = 8'h00;
        s_last  = 1'b0;
      end
    end
    check("drive_done", stream.size(), 0);
    stream.delete();
    s_valid = 1'b0;
  endtask

  task automatic wait_syms(input int n, input int budget);
    int cyc;
    cyc = 0;
    while (mon_q.size() < n && cyc < budget) begin
      cycle();
      cyc++;
    end
    check("sym_wait", mon_q.size() >= n, 1);
  endtask

  task automatic compare_seq(input string tag);
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("%s[%0d]", tag, i),
            (i < mon_q.size()) ? mon_q[i] : 9'h000, exp_q[i]);
    end
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = 8'h00;
    s_last  = 1'b0;
    repeat (3) cycle();
    check("rst_sym_out", sym_out, 9'h1BC);
    check("rst_sym_stb", sym_stb, 0);
    check("rst_s_ready", s_ready, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_trunc", trunc_err, 0);
    rst = 1'b0;
    mon_q.delete();
  endtask

  initial begin
    int         len;
    int         eof_seen;
    int         cyc;
    int         idles;
    bit         in_frame;
    bit         trunc_exp;
    logic [7:0] b;
    logic [7:0] chk;
    logic [8:0] ref_q[$];
    logic [8:0] got_q[$];

    // 1) Idle link after reset: strobe every SYM_DIV cycles, never ready.
    do_reset();
    for (int k = 1; k <= 50; k++) begin
      cycle();
      check($sformatf("idle_stb_c%0d", k), sym_stb, (k % SYM_DIV) == 0);
      check($sformatf("idle_sym_c%0d", k), sym_out, 9'h1BC);
      check($sformatf("idle_rdy_c%0d", k), s_ready, 0);
    end

    // 2) Basic 3-byte frame, source always valid.
    do_reset();
    push_beat(8'h12, 1'b0, 0);
    push_beat(8'h34, 1'b0, 0);
    push_beat(8'h56, 1'b1, 0);
    drive(500);
    exp_q = '{9'h1BC, 9'h1BC, 9'h13C, 9'h012, 9'h034, 9'h056, 9'h070, 9'h1FD, 9'h1BC};
    wait_syms(exp_q.size(), 200);
    compare_seq("basic");
    check("basic_frame_cnt", frame_cnt, 1);
    check("basic_trunc", trunc_err, 0);

    // 3) Source stalls two symbol periods after 0x34: fills, checksum unchanged.
    do_reset();
    push_beat(8'h12, 1'b0, 0);
    push_beat(8'h34, 1'b0, 0);
    push_beat(8'h56, 1'b1, 2 * SYM_DIV);
    drive(800);
    exp_q = '{9'h1BC, 9'h1BC, 9'h13C, 9'h012, 9'h034, 9'h1BC, 9'h1BC, 9'h056, 9'h070, 9'h1FD};
    wait_syms(exp_q.size(), 200);
    compare_seq("stall");
    check("stall_frame_cnt", frame_cnt, 1);

    // 4) 7-byte frame with MAX_LEN = 4: truncated, tail drained.
    do_reset();
    for (int i = 1; i <= 7; i++) push_beat(8'(i), i == 7, 0);
    drive(800);
    exp_q = '{9'h1BC, 9'h1BC, 9'h13C, 9'h001, 9'h002, 9'h003, 9'h004,
              9'h1BC, 9'h004, 9'h1FD, 9'h1BC};
    wait_syms(exp_q.size(), 200);
    compare_seq("trunc");
    check("trunc_flag", trunc_err, 1);
    check("trunc_frame_cnt", frame_cnt, 1);

    // 5) Exactly MAX_LEN bytes with last on the final one: no truncation.
    do_reset();
    push_beat(8'h11, 1'b0, 0);
    push_beat(8'h22, 1'b0, 0);
    push_beat(8'h44, 1'b0, 0);
    push_beat(8'h88, 1'b1, 0);
    drive(800);
    exp_q = '{9'h1BC, 9'h1BC, 9'h13C, 9'h011, 9'h022, 9'h044, 9'h088, 9'h0FF, 9'h1FD};
    wait_syms(exp_q.size(), 200);
    compare_seq("maxlen");
    check("maxlen_trunc", trunc_err, 0);

    // 6) Back-to-back single-byte frames.
    do_reset();
    push_beat(8'hAA, 1'b1, 0);
    push_beat(8'h55, 1'b1, 0);
    drive(800);
    exp_q = '{9'h1BC, 9'h1BC, 9'h13C, 9'h0AA, 9'h0AA, 9'h1FD, 9'h1BC, 9'h1BC,
              9'h13C, 9'h055, 9'h055, 9'h1FD};
    wait_syms(exp_q.size(), 200);
    compare_seq("b2b");
    check("b2b_frame_cnt", frame_cnt, 2);

    // 7) Reset in the middle of a frame, then a fresh frame.
    mon_q.delete();
    push_beat(8'h77, 1'b0, 0);
    push_beat(8'h66, 1'b0, 0);
    drive(800);
    check("mid_last_sym", (mon_q.size() > 0) ? mon_q[mon_q.size()-1] : 9'h000, 9'h066);
    rst = 1'b1;
    cycle();
    check("mid_rst_sym", sym_out, 9'h1BC);
    check("mid_rst_rdy", s_ready, 0);
    check("mid_rst_cnt", frame_cnt, 0);
    check("mid_rst_stb", sym_stb, 0);
    rst = 1'b0;
    mon_q.delete();
    push_beat(8'h5A, 1'b1, 0);
    drive(800);
    exp_q = '{9'h1BC, 9'h1BC, 9'h13C, 9'h05A, 9'h05A, 9'h1FD};
    wait_syms(exp_q.size(), 200);
    compare_seq("after_rst");
    check("after_rst_cnt", frame_cnt, 1);

    // 8) Random frames with random source gaps against the frame-level model.
    do_reset();
    ref_q.delete();
    trunc_exp = 1'b0;
    for (int f = 0; f < N_RAND; f++) begin
      len = (f == 0) ? 6 : $urandom_range(7, 1);
      chk = 8'h00;
      ref_q.push_back(S_SOF);
      for (int j = 0; j < len; j++) begin
        b = 8'($urandom);
        push_beat(b, j == len - 1, $urandom_range(25, 0));
        if (j < MAX_LEN) begin
          ref_q.push_back({1'b0, b});
          chk = chk ^ b;
        end
      end
      if (len > MAX_LEN) trunc_exp = 1'b1;
      ref_q.push_back({1'b0, chk});
      ref_q.push_back(S_EOF);
    end
    drive(40000);
    eof_seen = 0;
    cyc = 0;
    while (cyc < 2000) begin
      eof_seen = 0;
      foreach (mon_q[i]) if (mon_q[i] == S_EOF) eof_seen++;
      if (eof_seen >= N_RAND) break;
      cycle();
      cyc++;
    end
    check("rand_eof_count", eof_seen, N_RAND);
    cycle();

    got_q.delete();
    idles    = 0;
    in_frame = 1'b0;
    foreach (mon_q[i]) begin
      if (mon_q[i] != S_IDLE) got_q.push_back(mon_q[i]);
      if (mon_q[i] == S_SOF) begin
        check($sformatf("rand_idle_gap@%0d", i), idles >= MIN_IDLE, 1);
        in_frame = 1'b1;
      end else if (mon_q[i] == S_EOF) begin
        in_frame = 1'b0;
        idles    = 0;
      end else if (mon_q[i] == S_IDLE && !in_frame) begin
        idles++;
      end
    end
    check("rand_len", got_q.size(), ref_q.size());
    for (int i = 0; i < ref_q.size(); i++) begin
      check($sformatf("rand_sym[%0d]", i), (i < got_q.size()) ? got_q[i] : 9'h000, ref_q[i]);
    end
    check("rand_frame_cnt", frame_cnt, N_RAND);
    check("rand_trunc", trunc_err, trunc_exp);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
